// File: rtl/i2c_config_sequencer.sv
// Write-only I2C master that pushes NUM_WORDS table words to a codec, one transaction per word,
// with open-drain SDA, real ACK sampling and per-word NACK retry.
//
// state   | meaning
// IDLE    | bus released, waiting for i_start
// START   | START condition, 4 quarters
// DATA    | one data bit per 4-quarter slot, MSB first
// ACK     | SDA released, slave ACK sampled at end of Q2
// STOP    | STOP condition, then next word / retry / done / error
// DONE    | all words ACKed
// ERROR   | retries exhausted on o_err_idx
module i2c_config_sequencer #(
    parameter int NUM_WORDS      = 11,
    parameter int BYTES_PER_WORD = 3,
    parameter int CLK_DIV        = 4,
    parameter int MAX_RETRY      = 3,
    parameter int IDX_W          = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    output logic [IDX_W-1:0]            o_word_idx,
    input  logic [8*BYTES_PER_WORD-1:0] i_word,
    output logic                        o_busy,
    output logic                        o_finished,
    output logic                        o_error,
    output logic [IDX_W-1:0]            o_err_idx,
    output logic                        o_sclk,
    output logic                        o_sda_low,
    input  logic                        i_sda
);
    localparam int WW = 8 * BYTES_PER_WORD;
    localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [QW-1:0]    QCNT_LOAD = QW'(CLK_DIV - 1);
    localparam logic [BW-1:0]    LAST_BYTE = BW'(BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_ACK, S_STOP, S_DONE, S_ERROR
    } state_t;

    state_t          state;
    logic [QW-1:0]   qcnt;
    logic [1:0]      quarter;
    logic [2:0]      bit_cnt;
    logic [BW-1:0]   byte_cnt;
    logic [WW-1:0]   sreg;
    logic            nack;
    logic [RW-1:0]   retry;

    // Bus outputs are registered from the current position, so they trail it by one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            quarter    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            sreg       <= '0;
            nack       <= 1'b0;
            retry      <= '0;
            o_word_idx <= '0;
            o_err_idx  <= '0;
            o_busy     <= 1'b0;
            o_finished <= 1'b0;
            o_error    <= 1'b0;
            o_sclk     <= 1'b1;
            o_sda_low  <= 1'b0;
        end else begin
            case (state)
                S_START: begin
                    o_sclk    <= (quarter != 2'd3);
                    o_sda_low <= (quarter >= 2'd2);
                end
                S_DATA: begin
                    o_sclk    <= (quarter == 2'd1) || (quarter == 2'd2);
                    o_sda_low <= ~sreg[WW-1];
                end
                S_ACK: begin
                    o_sclk    <= (quarter == 2'd1) || (quarter == 2'd2);
                    o_sda_low <= 1'b0;
                end
                S_STOP: begin
                    o_sclk    <= (quarter != 2'd0);
                    o_sda_low <= (quarter <= 2'd1);
                end
                default: begin
                    o_sclk    <= 1'b1;
                    o_sda_low <= 1'b0;
                end
            endcase

            if (state == S_IDLE || state == S_DONE || state == S_ERROR) begin
                if (i_start) begin
                    state      <= S_START;
                    qcnt       <= QCNT_LOAD;
                    quarter    <= '0;
                    o_word_idx <= '0;
                    retry      <= '0;
                    o_finished <= 1'b0;
                    o_error    <= 1'b0;
                    o_busy     <= 1'b1;
                end
            end else if (qcnt != '0) begin
                qcnt <= qcnt - 1'b1;
            end else begin
                qcnt    <= QCNT_LOAD;
                quarter <= quarter + 2'd1;
                if (state == S_ACK && quarter == 2'd2)
                    nack <= i_sda;
                if (quarter == 2'd3) begin
                    case (state)
                        S_START: begin
                            state    <= S_DATA;
                            sreg     <= i_word;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            nack     <= 1'b0;
                        end
                        S_DATA: begin
                            sreg <= sreg << 1;
                            if (bit_cnt == 3'd7)
                                state <= S_ACK;
                            else
                                bit_cnt <= bit_cnt + 3'd1;
                        end
                        S_ACK: begin
                            if (nack || byte_cnt == LAST_BYTE) begin
                                state <= S_STOP;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                                bit_cnt  <= '0;
                                state    <= S_DATA;
                            end
                        end
                        S_STOP: begin
                            if (!nack) begin
                                if (o_word_idx == LAST_IDX) begin
                                    state      <= S_DONE;
                                    o_finished <= 1'b1;
                                    o_busy     <= 1'b0;
                                end else begin
                                    o_word_idx <= o_word_idx + 1'b1;
                                    retry      <= '0;
                                    state      <= S_START;
                                end
                            end else if (retry < RETRY_MAX) begin
                                retry <= retry + 1'b1;
                                state <= S_START;
                            end else begin
                                state     <= S_ERROR;
                                o_error   <= 1'b1;
                                o_err_idx <= o_word_idx;
                                o_busy    <= 1'b0;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Randomized bench for i2c_config_sequencer: a bus-level slave/monitor decodes the I2C traffic and
// a transaction-list model predicts words, retries, flags and total duration.
module tb_i2c_config_sequencer;
    localparam int NW  = 11;
    localparam int BPW = 3;
    localparam int CD  = 2;
    localparam int MR  = 3;
    localparam int IW  = 4;
    localparam int WW  = 8 * BPW;

    typedef struct {
        int            idx;
        int            nb;
        logic [WW-1:0] data;
        bit            nack;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [IW-1:0] word_idx;
    logic [WW-1:0] word;
    logic          busy, finished, error, sclk, sda_low;
    logic [IW-1:0] err_idx;
    logic          sda_line;
    logic          slave_low = 1'b0;

    logic [WW-1:0] tbl [NW];
    int n_chk = 0;
    int n_pass = 0;

    int nack_idx = -1, nack_att = 0, nack_byte = 0;
    int run_no = 0;

    txn_t log_q[$];
    txn_t exp_q[$];
    int   ack_bad = 0;

    always #5 clk = ~clk;

    assign sda_line = !(sda_low || slave_low);
    assign word = (int'(word_idx) < NW) ? tbl[word_idx] : '0;

    i2c_config_sequencer #(
        .NUM_WORDS(NW), .BYTES_PER_WORD(BPW), .CLK_DIV(CD), .MAX_RETRY(MR), .IDX_W(IW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_word_idx(word_idx),
        .i_word(word), .o_busy(busy), .o_finished(finished), .o_error(error),
        .o_err_idx(err_idx), .o_sclk(sclk), .o_sda_low(sda_low), .i_sda(sda_line)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Slave + monitor: decodes START/STOP/bits at negedge and pulls SDA low to ACK.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, in_txn = 1'b0;
    int         bcnt = 0, cur_att = 0, seen_run = 0;
    logic [7:0] cur_byte = '0;
    txn_t       cur;
    int         att_cnt [NW];

    always @(negedge clk) begin
        logic scl_s, sda_s;
        scl_s = sclk;
        sda_s = sda_line;
        if (run_no != seen_run) begin
            seen_run = run_no;
            for (int i = 0; i < NW; i++) att_cnt[i] = 0;
        end
        if (prev_scl && scl_s && prev_sda && !sda_s) begin
            in_txn   = 1'b1;
            bcnt     = 0;
            cur.idx  = int'(word_idx);
            cur.nb   = 0;
            cur.data = '0;
            cur.nack = 1'b0;
            cur_att  = (cur.idx < NW) ? att_cnt[cur.idx] : 0;
            if (cur.idx < NW) att_cnt[cur.idx]++;
        end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
            if (in_txn) log_q.push_back(cur);
            in_txn = 1'b0;
        end else if (!prev_scl && scl_s && in_txn) begin
            if (bcnt < 8) begin
                cur_byte = {cur_byte[6:0], sda_s};
                bcnt++;
            end else begin
                if (sda_low) ack_bad++;
                cur.data = {cur.data[WW-9:0], cur_byte};
                cur.nb++;
                if (sda_s) cur.nack = 1'b1;
                bcnt = 0;
            end
        end else if (prev_scl && !scl_s && in_txn) begin
            if (bcnt == 8)
                slave_low = !((cur.idx == nack_idx) && (cur_att < nack_att) && (cur.nb == nack_byte));
            else
                slave_low = 1'b0;
        end
        if (!rst_n) begin
            in_txn    = 1'b0;
            slave_low = 1'b0;
        end
        if (!busy) slave_low = 1'b0;
        prev_scl = scl_s;
        prev_sda = sda_s;
    end

    task automatic run(input int n_idx, input int n_att, input int n_byte, input bit extra);
        int   cyc, cnt, base, ack_base, extra_at;
        bit   exp_err;
        int   err_at;
        txn_t e;
        bit   nk;
        int   nb;
        nack_idx  = n_idx;
        nack_att  = n_att;
        nack_byte = n_byte;
        run_no++;
        exp_q.delete();
        cyc = 0; exp_err = 0; err_at = 0;
        for (int i = 0; i < NW && !exp_err; i++) begin
            for (int a = 0; a <= MR; a++) begin
                nk = (i == n_idx) && (a < n_att);
                nb = nk ? n_byte + 1 : BPW;
                e.idx = i; e.nb = nb; e.nack = nk;
                e.data = tbl[i] >> (8 * (BPW - nb));
                exp_q.push_back(e);
                cyc += 4 * (2 + 9 * nb) * CD;
                if (!nk) break;
                if (a == MR) begin exp_err = 1; err_at = i; end
            end
        end
        extra_at = extra ? int'($urandom_range(5, 300)) : -1;
        @(negedge clk);
        base = log_q.size();
        ack_base = ack_bad;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_on", int'(busy), 1);
        chk("flags_clr", int'({finished, error}), 0);
        cnt = 0;
        while (cnt < 20000) begin
            @(posedge clk);
            #1;
            cnt++;
            start = (cnt == extra_at);
            if (finished || error) break;
        end
        start = 1'b0;
        chk("duration", cnt, cyc);
        chk("finished", int'(finished), int'(!exp_err));
        chk("error", int'(error), int'(exp_err));
        if (exp_err) chk("err_idx", int'(err_idx), err_at);
        chk("busy_off", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("bus_idle", int'({sclk, sda_low}), 2);
        chk("n_txn", log_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < log_q.size(); i++) begin
            chk("txn_idx", log_q[base+i].idx, exp_q[i].idx);
            chk("txn_nbytes", log_q[base+i].nb, exp_q[i].nb);
            chk("txn_data", int'(log_q[base+i].data), int'(exp_q[i].data));
            chk("txn_nack", int'(log_q[base+i].nack), int'(exp_q[i].nack));
        end
        chk("ack_released", ack_bad - ack_base, 0);
    endtask

    task automatic reset_mid_word5();
        int cnt;
        nack_idx = -1;
        run_no++;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (int'(word_idx) != 5 && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
        chk("reach_idx5", int'(int'(word_idx) == 5), 1);
        repeat ($urandom_range(20, 150)) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_sclk", int'(sclk), 1);
        chk("rst_sda", int'(sda_low), 0);
        chk("rst_flags", int'({busy, finished, error}), 0);
        chk("rst_idx", int'(word_idx), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        tbl[0] = 24'h341E00;
        for (int i = 1; i < NW; i++) tbl[i] = WW'($urandom);
        repeat (3) @(negedge clk);
        chk("reset_bus", int'({sclk, sda_low}), 2);
        chk("reset_flags", int'({busy, finished, error}), 0);
        chk("reset_idx", int'({word_idx, err_idx}), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        run(-1, 0, 0, 1'b0);
        run(4, 1, BPW - 1, 1'b1);
        run(2, 100, 0, 1'b0);
        run(-1, 0, 0, 1'b1);
        for (int k = 0; k < 3; k++)
            run(int'($urandom_range(0, NW - 1)), int'($urandom_range(0, MR + 2)),
                int'($urandom_range(0, BPW - 1)), 1'($urandom_range(0, 1)));
        reset_mid_word5();
        run(-1, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
